reward: RTL and testbench
=========================

Name: reward

Overview:
- Builds the reward (Q-value feedback) packet for the EER-RL clustered WSN node.
- Triggers when the node is the destination of a received data packet.
- Scans the neighbor table for the current next hop (chosenHop), then registers a reward packet carrying this node's state.
- Sits between packetFilter/MY_NODE_INFO/KCH/QTUFMB/neighborTable and the packet transmit path.

Parameters:
- WORD_WIDTH, 16, width of all ID/energy/Q/hop fields.
- TABLE_DEPTH, 64, number of neighbor-table entries; index is 6 bits.

Ports:
- clk  in  1  single clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- en  in  1  block enable.
- fPacketType  in  3  type of the received packet.
- myEnergy  in  16  own residual energy; 16'h8000 = full.
- iHaveData  in  1  own data pending; reserved, no effect.
- iAmDestination  in  1  received packet is addressed to this node.
- myNodeID, hopsFromSink, myQValue  in  16 each  own node info.
- role  in  1  1 = cluster head.
- low_E  in  1  own energy below threshold.
- chosenCH, hopsFromCH  in  16 each  joined cluster head and hop count to it.
- chosenHop  in  16  next hop selected by QTUFMB.
- mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops  in  16 each  neighbor-table read data at nTableIndex_reward.
- rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH  out  16 each  reward packet fields.
- rPacketType  out  3  reward packet type.
- nTableIndex_reward  out  6  neighbor-table read index.
- reward_done  out  1  one-cycle pulse when the packet fields are valid.

Behaviour:
- Reset (nrst=0 at a clk edge): all outputs 0, FSM = IDLE.
- Trigger: en && fPacketType==PKT_DATA && iAmDestination, sampled in IDLE.
- Neighbor-table read latency is 1 cycle: mNode* is valid the cycle after the index is driven.

FSM states: IDLE, READ, CMP, BUILD.
- IDLE, on trigger: snapshot myNodeID, myEnergy, myQValue, hopsFromSink, role, low_E, chosenCH, hopsFromCH, chosenHop; index <= 0; go to READ.
- READ: wait one cycle; go to CMP.
- CMP, mNodeID == snapshot chosenHop: found = 1; go to BUILD.
- CMP, mNodeID == 0 (empty slot, end of table) or index == TABLE_DEPTH-1: found = 0; go to BUILD.
- CMP, otherwise: index++; go to READ.
- BUILD: register all outputs, pulse reward_done = 1 for exactly one cycle, go to IDLE.
- Scan cost: 2 cycles per entry.

Fields registered in BUILD:
- rSourceID = myNodeID; rEnergyLeft = myEnergy; rSourceHops = hopsFromSink; rPacketType = PKT_REWARD.
- rQValue = myQValue, or 0 if low_E (discourages routing through a depleted node).
- rDestinationID = chosenHop if found, else 16'hFFFF (broadcast).
- role == 1: rChosenCH = myNodeID, rHopsFromCH = 0. role == 0: rChosenCH = chosenCH, rHopsFromCH = hopsFromCH.

Other rules:
- Outputs hold their values until the next BUILD or reset.
- en == 0 in any non-IDLE state aborts to IDLE: no reward_done, outputs unchanged, index reset to 0.
- Triggers arriving while not in IDLE are ignored.
- chosenHop == 0 never matches a valid entry, so the scan ends at the first empty slot and the packet is broadcast.
- Reset mid-scan wins over every other condition.
- No arithmetic beyond the 6-bit index increment; the index never wraps because the scan stops at TABLE_DEPTH-1.

Decomposition:
- Shared package eer_rl_pkg holds:
  - WORD_WIDTH.
  - Packet-type constants PKT_DATA = 3'd3, PKT_REWARD = 3'd5.
  - BROADCAST_ID = 16'hFFFF.
  - Reward FSM state enum.
- Single module; no sub-module required.

Test Plan:
- Reset: nrst=0 for 2 cycles -> all outputs 0, reward_done 0.
- Found at entry 2: myNodeID=5, myEnergy=16'h8000, myQValue=16'h0400, hopsFromSink=3, chosenHop=9, table IDs {7,8,9,0}, role=0, chosenCH=2, hopsFromCH=1, low_E=0, trigger with fPacketType=PKT_DATA, iAmDestination=1 -> reward_done pulses 7 cycles after trigger with rDestinationID=9, rSourceID=5, rQValue=16'h0400, rSourceHops=3, rChosenCH=2, rHopsFromCH=1, rPacketType=5.
- Not found: chosenHop=12, table IDs {7,8,0} -> rDestinationID=16'hFFFF; the scan stops at index 2.
- CH and low energy: role=1, low_E=1 -> rChosenCH=myNodeID, rHopsFromCH=0, rQValue=0.
- Non-trigger and abort:
  - fPacketType=PKT_REWARD, or iAmDestination=0 -> no reward_done, index stays 0.
  - en dropped during the scan -> return to IDLE, no pulse, outputs unchanged.
- Full table: 64 non-matching nonzero IDs -> the scan reaches index 63 and reward_done pulses with rDestinationID=16'hFFFF.

Source files
------------

// File: rtl/eer_rl_pkg.sv
// Shared EER-RL node definitions: field widths, packet-type codes and the
// state/record types used by the reward-packet builder.
package eer_rl_pkg;

    localparam int WORD_WIDTH  = 16;
    localparam int TABLE_DEPTH = 64;
    localparam int IDX_WIDTH   = $clog2(TABLE_DEPTH);

    localparam logic [2:0] PKT_DATA   = 3'd3;
    localparam logic [2:0] PKT_REWARD = 3'd5;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;

    localparam word_t BROADCAST_ID = 16'hFFFF;
    localparam idx_t  LAST_IDX     = IDX_WIDTH'(TABLE_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CMP,
        ST_BUILD
    } reward_state_e;

    // Own node state captured at trigger time so the packet is self-consistent
    typedef struct packed {
        word_t node_id;
        word_t energy;
        word_t q_value;
        word_t hops;
        word_t ch;
        word_t ch_hops;
        word_t hop;
        logic  role;
        logic  low_e;
    } reward_snap_t;

    typedef struct packed {
        word_t      src_id;
        word_t      energy_left;
        word_t      q_value;
        word_t      src_hops;
        word_t      dest_id;
        word_t      chosen_ch;
        word_t      hops_from_ch;
        logic [2:0] ptype;
    } reward_pkt_t;

    function automatic reward_pkt_t build_pkt(input reward_snap_t s, input logic found);
        reward_pkt_t p;
        p.src_id       = s.node_id;
        p.energy_left  = s.energy;
        // A depleted node advertises Q=0 so neighbours route around it
        p.q_value      = s.low_e ? '0 : s.q_value;
        p.src_hops     = s.hops;
        p.dest_id      = found ? s.hop : BROADCAST_ID;
        p.chosen_ch    = s.role ? s.node_id : s.ch;
        p.hops_from_ch = s.role ? '0 : s.ch_hops;
        p.ptype        = PKT_REWARD;
        return p;
    endfunction

endpackage

// File: rtl/reward_if.sv
// Signal bundle between the reward builder and its surroundings: node info,
// neighbor-table read port and the outgoing reward packet fields.
interface reward_if;
    import eer_rl_pkg::*;

    logic       en;
    logic [2:0] fPacketType;
    word_t      myEnergy;
    logic       iHaveData;
    logic       iAmDestination;
    word_t      myNodeID;
    word_t      hopsFromSink;
    word_t      myQValue;
    logic       role;
    logic       low_E;
    word_t      chosenCH;
    word_t      hopsFromCH;
    word_t      chosenHop;
    word_t      mNodeID;
    word_t      mNodeHops;
    word_t      mNodeQValue;
    word_t      mNodeEnergy;
    word_t      mNodeCHHops;

    word_t      rSourceID;
    word_t      rEnergyLeft;
    word_t      rQValue;
    word_t      rSourceHops;
    word_t      rDestinationID;
    word_t      rChosenCH;
    word_t      rHopsFromCH;
    logic [2:0] rPacketType;
    idx_t       nTableIndex_reward;
    logic       reward_done;

    modport master (
        output en, fPacketType, myEnergy, iHaveData, iAmDestination, myNodeID,
               hopsFromSink, myQValue, role, low_E, chosenCH, hopsFromCH, chosenHop,
               mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops,
        input  rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID,
               rChosenCH, rHopsFromCH, rPacketType, nTableIndex_reward, reward_done
    );

    modport slave (
        input  en, fPacketType, myEnergy, iHaveData, iAmDestination, myNodeID,
               hopsFromSink, myQValue, role, low_E, chosenCH, hopsFromCH, chosenHop,
               mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops,
        output rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID,
               rChosenCH, rHopsFromCH, rPacketType, nTableIndex_reward, reward_done
    );

endinterface

// File: rtl/reward.sv
// Reward packet builder: on a received data packet addressed to this node,
// scans the neighbor table for the chosen next hop and registers a reward packet.
module reward
    import eer_rl_pkg::*;
(
    input  logic     clk,
    input  logic     nrst,
    reward_if.slave  bus
);

    reward_state_e state_q, state_d;
    idx_t          idx_q, idx_d;
    reward_snap_t  snap_q, snap_d;
    logic          found_q, found_d;
    reward_pkt_t   pkt_q, pkt_d;
    logic          done_q, done_d;
    logic          trigger;
    logic          unused_ok;

    assign trigger = bus.en && (bus.fPacketType == PKT_DATA) && bus.iAmDestination;

    // Neighbor metrics other than the ID do not influence the reward packet
    assign unused_ok = ^{bus.iHaveData, bus.mNodeHops, bus.mNodeQValue,
                         bus.mNodeEnergy, bus.mNodeCHHops};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        found_d = found_q;
        pkt_d   = pkt_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    snap_d.node_id = bus.myNodeID;
                    snap_d.energy  = bus.myEnergy;
                    snap_d.q_value = bus.myQValue;
                    snap_d.hops    = bus.hopsFromSink;
                    snap_d.ch      = bus.chosenCH;
                    snap_d.ch_hops = bus.hopsFromCH;
                    snap_d.hop     = bus.chosenHop;
                    snap_d.role    = bus.role;
                    snap_d.low_e   = bus.low_E;
                    idx_d          = '0;
                    found_d        = 1'b0;
                    state_d        = ST_READ;
                end
            end
            ST_READ: state_d = ST_CMP;
            ST_CMP: begin
                // An empty slot never counts as a match, even for chosenHop == 0
                if ((bus.mNodeID != '0) && (bus.mNodeID == snap_q.hop)) begin
                    found_d = 1'b1;
                    state_d = ST_BUILD;
                end else if ((bus.mNodeID == '0) || (idx_q == LAST_IDX)) begin
                    found_d = 1'b0;
                    state_d = ST_BUILD;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_BUILD: begin
                pkt_d   = build_pkt(snap_q, found_q);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && !bus.en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            pkt_d   = pkt_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            found_q <= 1'b0;
            pkt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            found_q <= found_d;
            pkt_q   <= pkt_d;
            done_q  <= done_d;
        end
    end

    assign bus.rSourceID          = pkt_q.src_id;
    assign bus.rEnergyLeft        = pkt_q.energy_left;
    assign bus.rQValue            = pkt_q.q_value;
    assign bus.rSourceHops        = pkt_q.src_hops;
    assign bus.rDestinationID     = pkt_q.dest_id;
    assign bus.rChosenCH          = pkt_q.chosen_ch;
    assign bus.rHopsFromCH        = pkt_q.hops_from_ch;
    assign bus.rPacketType        = pkt_q.ptype;
    assign bus.nTableIndex_reward = idx_q;
    assign bus.reward_done        = done_q;

endmodule

// File: tb/tb_reward.sv
// Scoreboard bench for the reward builder: a behavioural neighbor table with a
// one-cycle read, expected packets queued at trigger and checked on reward_done.
module tb_reward;
    import eer_rl_pkg::*;

    typedef struct {
        word_t      src, energy, q, hops, dest, ch, chhops;
        logic [2:0] ptype;
        int         lat;
        int         idx;
        int         trig_cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  nrst;
    int    cyc = 0;
    int    checks_cnt = 0;
    int    errors_cnt = 0;
    int    done_cnt = 0;
    word_t tbl_id [TABLE_DEPTH];
    exp_t  sb [$];
    exp_t  last_exp;

    reward_if rif ();

    reward u_dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (rif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rif.mNodeID     <= tbl_id[rif.nTableIndex_reward];
        rif.mNodeHops   <= tbl_id[rif.nTableIndex_reward] + 16'd1;
        rif.mNodeQValue <= 16'h0100;
        rif.mNodeEnergy <= 16'h4000;
        rif.mNodeCHHops <= 16'd2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        logic found = 1'b0;
        int   stop  = 0;
        for (int k = 0; k < TABLE_DEPTH; k++) begin
            stop = k;
            if (tbl_id[k] == 16'd0) break;
            if (tbl_id[k] == rif.chosenHop) begin
                found = 1'b1;
                break;
            end
        end
        e.src      = rif.myNodeID;
        e.energy   = rif.myEnergy;
        e.q        = rif.low_E ? 16'd0 : rif.myQValue;
        e.hops     = rif.hopsFromSink;
        e.dest     = found ? rif.chosenHop : 16'hFFFF;
        e.ch       = rif.role ? rif.myNodeID : rif.chosenCH;
        e.chhops   = rif.role ? 16'd0 : rif.hopsFromCH;
        e.ptype    = 3'd5;
        e.lat      = 2 * stop + 3;
        e.idx      = stop;
        e.trig_cyc = 0;
        return e;
    endfunction

    task automatic set_node(input word_t id, input word_t energy, input word_t q,
                            input word_t hops, input word_t ch, input word_t chhops,
                            input word_t hop, input logic role, input logic low_e);
        rif.myNodeID     = id;
        rif.myEnergy     = energy;
        rif.myQValue     = q;
        rif.hopsFromSink = hops;
        rif.chosenCH     = ch;
        rif.hopsFromCH   = chhops;
        rif.chosenHop    = hop;
        rif.role         = role;
        rif.low_E        = low_e;
    endtask

    task automatic clear_tbl();
        for (int k = 0; k < TABLE_DEPTH; k++) tbl_id[k] = 16'd0;
    endtask

    // One-cycle request; a packet is expected only for a real trigger
    task automatic fire(input logic [2:0] ptype, input logic dest, input bit expect_pkt);
        exp_t e;
        @(negedge clk);
        rif.en             = 1'b1;
        rif.fPacketType    = ptype;
        rif.iAmDestination = dest;
        if (expect_pkt) begin
            e = model();
            e.trig_cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        rif.fPacketType    = 3'd0;
        rif.iAmDestination = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        logic done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_prev) check("done_width", 32'(rif.reward_done), 32'd0);
            done_prev = (rif.reward_done === 1'b1);
            if (rif.reward_done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", 32'(cyc - e.trig_cyc - 1), 32'(e.lat));
                    check("rDestinationID", 32'(rif.rDestinationID), 32'(e.dest));
                    check("rSourceID", 32'(rif.rSourceID), 32'(e.src));
                    check("rEnergyLeft", 32'(rif.rEnergyLeft), 32'(e.energy));
                    check("rQValue", 32'(rif.rQValue), 32'(e.q));
                    check("rSourceHops", 32'(rif.rSourceHops), 32'(e.hops));
                    check("rChosenCH", 32'(rif.rChosenCH), 32'(e.ch));
                    check("rHopsFromCH", 32'(rif.rHopsFromCH), 32'(e.chhops));
                    check("rPacketType", 32'(rif.rPacketType), 32'(e.ptype));
                    check("stop_index", 32'(rif.nTableIndex_reward), 32'(e.idx));
                    $display("pkt dest=%h src=%h q=%h ch=%h lat=%0d", rif.rDestinationID,
                             rif.rSourceID, rif.rQValue, rif.rChosenCH, cyc - e.trig_cyc - 1);
                    last_exp = e;
                end
            end
        end
    end

    initial begin : stim
        int done_before;
        nrst               = 1'b0;
        rif.en             = 1'b0;
        rif.fPacketType    = 3'd0;
        rif.iAmDestination = 1'b0;
        rif.iHaveData      = 1'b0;
        set_node(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        clear_tbl();

        repeat (2) @(negedge clk);
        check("rst_done", 32'(rif.reward_done), 32'd0);
        check("rst_dest", 32'(rif.rDestinationID), 32'd0);
        check("rst_src", 32'(rif.rSourceID), 32'd0);
        check("rst_ptype", 32'(rif.rPacketType), 32'd0);
        check("rst_index", 32'(rif.nTableIndex_reward), 32'd0);
        nrst = 1'b1;

        // Non-triggering requests
        tbl_id[0] = 16'd7; tbl_id[1] = 16'd8; tbl_id[2] = 16'd9;
        set_node(16'd5, 16'h8000, 16'h0400, 16'd3, 16'd2, 16'd1, 16'd9, 1'b0, 1'b0);
        fire(PKT_REWARD, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("wrongtype_index", 32'(rif.nTableIndex_reward), 32'd0);
        fire(PKT_DATA, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("notdest_index", 32'(rif.nTableIndex_reward), 32'd0);
        check("nontrig_pulses", 32'(done_cnt), 32'd0);
        check("nontrig_dest", 32'(rif.rDestinationID), 32'd0);

        // Found at entry 2
        fire(PKT_DATA, 1'b1, 1'b1);
        wait_done(40);

        // Not found, end of table at entry 2
        clear_tbl();
        tbl_id[0] = 16'd7; tbl_id[1] = 16'd8;
        set_node(16'd5, 16'h8000, 16'h0400, 16'd3, 16'd2, 16'd1, 16'd12, 1'b0, 1'b0);
        fire(PKT_DATA, 1'b1, 1'b1);
        wait_done(40);

        // Cluster head with low energy, found at entry 1
        set_node(16'd5, 16'h0200, 16'h0400, 16'd4, 16'd2, 16'd1, 16'd8, 1'b1, 1'b1);
        fire(PKT_DATA, 1'b1, 1'b1);
        wait_done(40);

        // chosenHop of 0 ends at the first empty slot and broadcasts
        set_node(16'd6, 16'h7000, 16'h0300, 16'd2, 16'd3, 16'd2, 16'd0, 1'b0, 1'b0);
        fire(PKT_DATA, 1'b1, 1'b1);
        wait_done(40);

        // Abort mid-scan by dropping en
        clear_tbl();
        tbl_id[0] = 16'd7; tbl_id[1] = 16'd8; tbl_id[2] = 16'd9;
        set_node(16'd11, 16'h1234, 16'h0055, 16'd7, 16'd4, 16'd3, 16'd9, 1'b0, 1'b0);
        done_before = done_cnt;
        fire(PKT_DATA, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rif.en = 1'b0;
        @(negedge clk);
        rif.en = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_pulses", 32'(done_cnt), 32'(done_before));
        check("abort_index", 32'(rif.nTableIndex_reward), 32'd0);
        check("abort_dest_held", 32'(rif.rDestinationID), 32'(last_exp.dest));
        check("abort_src_held", 32'(rif.rSourceID), 32'(last_exp.src));

        // Full table, no match: scan reaches the last entry
        for (int k = 0; k < TABLE_DEPTH; k++) tbl_id[k] = word_t'(100 + k);
        set_node(16'd5, 16'h8000, 16'h0400, 16'd3, 16'd2, 16'd1, 16'd12, 1'b0, 1'b0);
        fire(PKT_DATA, 1'b1, 1'b1);
        wait_done(200);

        check("total_pulses", 32'(done_cnt), 32'd5);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
